uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus (we/waddr/wdata/raddr/rdata), the same bus the ex stage drives towards ram.
- Software writes bytes into a 4-entry FIFO; the block serialises them as 8N1 frames on tx_o.
- Sits beside ram in the top level; the top decodes nothing, because the block self-selects on its base address.

---
 rtl/uart_tx_periph.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Four registers (CTRL, STATUS, BAUD, TXDATA) in a 16-byte window that the
// block decodes itself. A small TX FIFO feeds a start/data/stop serialiser.
// The FSM latches the bit period at frame start, so BAUD writes only take
// effect at the next frame.
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd4,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        tx_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Register and FIFO state
    logic            en_q, en_d;
    logic [15:0]     baud_q, baud_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;

    // Serialiser state
    logic [1:0]      state_q, state_d;
    logic [15:0]     div_q, div_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    // Bus decode
    logic            wsel, rsel;
    logic [1:0]      woff, roff;
    logic            wr_ctrl, wr_status, wr_baud, wr_txdata;
    logic            full, empty, busy;
    logic            pop, push_ok;

    // Address bits below word granularity and the upper data half are never used.
    logic            unused_bits;
    assign unused_bits = ^{waddr_i[1:0], raddr_i[1:0], wdata_i[31:16]};

    assign wsel      = (waddr_i[31:4] == BASE_ADDR[31:4]);
    assign rsel      = (raddr_i[31:4] == BASE_ADDR[31:4]);
    assign woff      = waddr_i[3:2];
    assign roff      = raddr_i[3:2];
    assign wr_ctrl   = we_i && wsel && (woff == 2'd0);
    assign wr_status = we_i && wsel && (woff == 2'd1);
    assign wr_baud   = we_i && wsel && (woff == 2'd2);
    assign wr_txdata = we_i && wsel && (woff == 2'd3);

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign busy  = (state_q != S_IDLE);

    // A frame starts (and the FIFO head is consumed) when IDLE sees EN with data queued.
    assign pop     = (state_q == S_IDLE) && en_q && !empty;
    // A push while full still lands if the same cycle frees a slot.
    assign push_ok = wr_txdata && (!full || pop);

    // Next-state for software-visible registers and FIFO bookkeeping
    always_comb begin
        en_d    = en_q;
        baud_d  = baud_q;
        ovf_d   = ovf_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (wr_ctrl) en_d   = wdata_i[0];
        if (wr_baud) baud_d = wdata_i[15:0];

        if (wr_txdata && full && !pop) ovf_d = 1'b1;
        // Clearing OVF wins over a same-cycle overflow: the write owns the field.
        if (wr_status && wdata_i[3])   ovf_d = 1'b0;

        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop)     rptr_d = rptr_q + PW'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Serialiser FSM: each state holds for div_q cycles counted down in cnt_q
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = fifo_q[rptr_q];
                    div_d   = (baud_q == 16'd0) ? 16'd1 : baud_q;
                    cnt_d   = div_d - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d     = div_q - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    // Line level follows the registered state, so reset forces idle-high immediately
    always_comb begin
        tx_o = 1'b1;
        if (state_q == S_START)     tx_o = 1'b0;
        else if (state_q == S_DATA) tx_o = shift_q[0];
    end

    // Zero-latency register read, zero outside the window
    always_comb begin
        rdata_o = 32'd0;
        if (rsel) begin
            case (roff)
                2'd0:    rdata_o = {31'd0, en_q};
                2'd1:    rdata_o = {28'd0, ovf_q, empty, full, busy};
                2'd2:    rdata_o = {16'd0, baud_q};
                default: rdata_o = 32'd0;
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset also discards the FIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q      <= 1'b0;
            baud_q    <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            div_q     <= 16'd1;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            en_q      <= en_d;
            baud_q    <= baud_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wptr_q] <= wdata_i[7:0];
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: a queue-based model of the register file, FIFO
// and line waveform checked every cycle, plus directed literal expectations.
module tb_uart_tx_periph;

    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] waddr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] raddr_i = 32'd0;
    logic [31:0] rdata_o;
    logic        tx_o;

    int total = 0;
    int bad   = 0;

    uart_tx_periph dut (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .raddr_i (raddr_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    logic        m_en;
    logic [15:0] m_baud;
    logic        m_ovf;
    logic [7:0]  m_fifo [$];
    bit          m_wave [$];   // line level for the current and upcoming cycles of a frame

    logic        m_hit, m_pop, m_full_old;
    logic [1:0]  m_off;
    logic [7:0]  m_byte;
    int          m_div;

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a[31:4] == B[31:4]) begin
            case (a[3:2])
                2'd0: r = {31'd0, m_en};
                2'd1: r = {28'd0, m_ovf, (m_fifo.size() == 0), (m_fifo.size() == 4),
                           (m_wave.size() != 0)};
                2'd2: r = {16'd0, m_baud};
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1'b1;
            m_en    = 1'b0;
            m_baud  = 16'd4;
            m_ovf   = 1'b0;
            m_fifo.delete();
            m_wave.delete();
        end else if (m_valid) begin
            m_hit      = (waddr_i[31:4] == B[31:4]);
            m_off      = waddr_i[3:2];
            m_full_old = (m_fifo.size() == 4);
            m_pop      = (m_wave.size() == 0) && m_en && (m_fifo.size() != 0);
            if (m_pop) begin
                m_byte = m_fifo.pop_front();
                m_div  = (m_baud == 16'd0) ? 1 : int'(m_baud);
                for (int i = 0; i < m_div; i++) m_wave.push_back(1'b0);
                for (int b = 0; b < 8; b++)
                    for (int i = 0; i < m_div; i++) m_wave.push_back(m_byte[b]);
                for (int i = 0; i < m_div; i++) m_wave.push_back(1'b1);
            end else if (m_wave.size() != 0) begin
                void'(m_wave.pop_front());
            end
            if (we_i && m_hit && m_off == 2'd3) begin
                if (m_full_old && !m_pop) m_ovf = 1'b1;
                else m_fifo.push_back(wdata_i[7:0]);
            end
            if (we_i && m_hit && m_off == 2'd1 && wdata_i[3]) m_ovf = 1'b0;
            if (we_i && m_hit && m_off == 2'd0) m_en = wdata_i[0];
            if (we_i && m_hit && m_off == 2'd2) m_baud = wdata_i[15:0];
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    logic        c_tx;
    logic [31:0] c_rd;
    always @(negedge clk) begin
        if (m_valid) begin
            c_tx = (m_wave.size() != 0) ? m_wave[0] : 1'b1;
            c_rd = exp_rdata(raddr_i);
            total++;
            if (tx_o !== c_tx) begin
                bad++;
                $display("FAIL model_tx t=%0t got=%b want=%b", $time, tx_o, c_tx);
            end
            total++;
            if (rdata_o !== c_rd) begin
                bad++;
                $display("FAIL model_rdata t=%0t addr=%h got=%h want=%h", $time, raddr_i, rdata_o, c_rd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        wdata_i = d;
        step();
        we_i    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] want);
        raddr_i = a;
        #1;
        chk(name, rdata_o, want);
    endtask

    bit lit55 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit litff [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset and register defaults
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rd_chk("rst_ctrl",   B + 32'h0, 32'h0);
        rd_chk("rst_status", B + 32'h4, 32'h4);
        rd_chk("rst_baud",   B + 32'h8, 32'h4);
        rd_chk("rst_txdata", B + 32'hC, 32'h0);
        chk("rst_tx", {31'd0, tx_o}, 32'd1);

        // Single 0x55 frame at 4 cycles/bit
        wr(B + 32'h0, 32'h1);
        raddr_i = B + 32'h4;
        wr(B + 32'hC, 32'h55);
        step();
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("f55_tx%0d", i), {31'd0, tx_o}, {31'd0, lit55[i/4]});
            chk($sformatf("f55_busy%0d", i), {31'd0, rdata_o[0]}, 32'd1);
            step();
        end
        chk("f55_after_status", rdata_o, 32'h4);
        chk("f55_after_tx", {31'd0, tx_o}, 32'd1);

        // Overflow with EN=0, then drain four frames
        wr(B + 32'h0, 32'h0);
        wr(B + 32'hC, 32'hA1);
        wr(B + 32'hC, 32'hB2);
        wr(B + 32'hC, 32'hC3);
        wr(B + 32'hC, 32'hD4);
        wr(B + 32'hC, 32'hE5);
        rd_chk("ovf_status", B + 32'h4, 32'hA);
        wr(B + 32'h0, 32'h1);
        repeat (170) step();
        rd_chk("drain_status", B + 32'h4, 32'hC);
        wr(B + 32'h4, 32'h8);
        rd_chk("ovf_clear", B + 32'h4, 32'h4);

        // BAUD change during DATA only affects the next frame
        wr(B + 32'hC, 32'h3C);
        wr(B + 32'hC, 32'h0F);
        repeat (7) step();
        wr(B + 32'h8, 32'h2);
        rd_chk("baud2", B + 32'h8, 32'h2);
        repeat (70) step();
        rd_chk("baud2_done", B + 32'h4, 32'h4);

        // BAUD=0 behaves as one cycle per bit
        wr(B + 32'h8, 32'h0);
        raddr_i = B + 32'h4;
        wr(B + 32'hC, 32'hFF);
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fff_tx%0d", i), {31'd0, tx_o}, {31'd0, litff[i]});
            step();
        end
        chk("fff_after_status", rdata_o, 32'h4);

        // Reset mid-frame aborts the frame and discards queued data
        wr(B + 32'h8, 32'h4);
        wr(B + 32'hC, 32'h00);
        wr(B + 32'hC, 32'h00);
        repeat (6) step();
        chk("pre_rst_tx", {31'd0, tx_o}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst_mid_tx", {31'd0, tx_o}, 32'd1);
        rst = 1'b1;
        step();
        rd_chk("rst_mid_status", B + 32'h4, 32'h4);
        wr(B + 32'h0, 32'h1);
        repeat (50) step();
        chk("rst_mid_idle_tx", {31'd0, tx_o}, 32'd1);
        rd_chk("rst_mid_idle_status", B + 32'h4, 32'h4);

        // Out-of-window accesses
        wr(B + 32'h1C, 32'h77);
        wr(32'h2000_000C, 32'h77);
        rd_chk("oow_status", B + 32'h4, 32'h4);
        rd_chk("oow_read_lo", 32'h2000_0004, 32'h0);
        rd_chk("oow_read_hi", B + 32'h14, 32'h0);
        repeat (20) step();
        chk("oow_tx", {31'd0, tx_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
